// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and the baud
// divider helper used by both the receiver and the future transmitter.
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // System clocks per oversample tick, rounded down
    function automatic int calcTickDiv(input int sysClk, input int baud, input int overSample);
        return sysClk / (baud * overSample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a free-running divider that emits a single-clk
// enable pulse every TICK_DIV system clocks while enabled.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int TICK_DIV = calcTickDiv(SYS_CLK, BAUD, OVERSAMPLE);
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 1) begin : gTickDivCheck
            $error("uart_baud_tick: SYS_CLK too slow for BAUD*OVERSAMPLE (TICK_DIV < 1)");
        end
    endgenerate

    logic [CNT_W-1:0] r_tickCnt;

    // Divider counter: held at zero while disabled, wraps after the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tickCnt <= '0;
        end else if (!enable) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt == TICK_LAST) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    assign tick = enable && (r_tickCnt == TICK_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, validates the start bit at
// mid-bit, assembles LSB-first data, checks the stop bit and hands each good
// word to the host through a level-valid / pulse-ack register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD       = 9600,
    parameter int SYS_CLK    = 12000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [SCNT_W-1:0] MID_CNT  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : gDataBitsCheck
            $error("uart_rx: DATA_BITS must be 5..9");
        end
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : gOversampleCheck
            $error("uart_rx: OVERSAMPLE must be even and at least 4");
        end
    endgenerate

    logic                 w_tick;
    logic                 r_sync1;
    logic                 r_rxs;
    rx_state_t            r_state;
    rx_state_t            w_nextState;
    logic [SCNT_W-1:0]    r_sampleCnt;
    logic [SCNT_W-1:0]    w_nextSampleCnt;
    logic [BIT_W-1:0]     r_bitIdx;
    logic [BIT_W-1:0]     w_nextBitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_nextShift;
    logic                 w_frameDone;

    uart_baud_tick #(
        .SYS_CLK    (SYS_CLK),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baudTick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (w_tick)
    );

    // Two-flop synchronizer for the asynchronous line; idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_wire;
            r_rxs   <= r_sync1;
        end
    end

    // Frame FSM state, sample/bit counters and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sampleCnt <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
        end else begin
            r_state     <= w_nextState;
            r_sampleCnt <= w_nextSampleCnt;
            r_bitIdx    <= w_nextBitIdx;
            r_shift     <= w_nextShift;
        end
    end

    // Next-state logic: advances only on ticks; disable aborts to IDLE
    always_comb begin
        w_nextState     = r_state;
        w_nextSampleCnt = r_sampleCnt;
        w_nextBitIdx    = r_bitIdx;
        w_nextShift     = r_shift;
        w_frameDone     = 1'b0;
        if (!enable) begin
            w_nextState     = IDLE;
            w_nextSampleCnt = '0;
            w_nextBitIdx    = '0;
        end else if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rxs) begin
                        w_nextState     = START;
                        w_nextSampleCnt = '0;
                    end
                end
                START: begin
                    if (r_sampleCnt == MID_CNT) begin
                        w_nextSampleCnt = '0;
                        w_nextBitIdx    = '0;
                        w_nextState     = r_rxs ? IDLE : DATA;
                    end else begin
                        w_nextSampleCnt = r_sampleCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_sampleCnt == LAST_CNT) begin
                        w_nextShift     = {r_rxs, r_shift[DATA_BITS-1:1]};
                        w_nextSampleCnt = '0;
                        if (r_bitIdx == LAST_BIT) begin
                            w_nextBitIdx = '0;
                            w_nextState  = STOP;
                        end else begin
                            w_nextBitIdx = r_bitIdx + 1'b1;
                        end
                    end else begin
                        w_nextSampleCnt = r_sampleCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_sampleCnt == LAST_CNT) begin
                        w_nextState     = IDLE;
                        w_nextSampleCnt = '0;
                        w_frameDone     = 1'b1;
                    end else begin
                        w_nextSampleCnt = r_sampleCnt + 1'b1;
                    end
                end
                default: begin
                    w_nextState     = IDLE;
                    w_nextSampleCnt = '0;
                    w_nextBitIdx    = '0;
                end
            endcase
        end
    end

    // Host handshake: deliver good words, pulse framing/overrun errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= w_frameDone && !r_rxs;
            overrun       <= 1'b0;
            if (w_frameDone && r_rxs) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized run
// compared against a word-level model of the receive handshake.
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       rx_wire;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       framing_error;
    logic       overrun;

    int assertCount = 0;
    int failCount   = 0;
    int feSeen      = 0;
    int ovSeen      = 0;

    uart_rx #(
        .DATA_BITS  (8),
        .BAUD       (100000),
        .SYS_CLK    (1600000),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .rx_wire       (rx_wire),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ack        (rx_ack),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every clk during which an error pulse is high
    always @(negedge clk) begin
        if (framing_error) feSeen++;
        if (overrun) ovSeen++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        enable  = 1'b1;
        rx_wire = 1'b1;
        rx_ack  = 1'b0;
        idle(20);
        rst = 1'b0;
        idle(4);
    endtask

    // Drive a serial frame (start, data LSB first, stop), optionally cut short
    task automatic drive_line(input logic [7:0] data, input logic stopBit, input int maxClks);
        logic [9:0] lineBits;
        int         clkCount;
        lineBits = {stopBit, data, 1'b0};
        clkCount = 0;
        for (int b = 0; b < 10; b++) begin
            rx_wire = lineBits[0];
            lineBits = lineBits >> 1;
            for (int c = 0; c < BIT_CLKS; c++) begin
                if (clkCount < maxClks) begin
                    @(negedge clk);
                    clkCount++;
                end
            end
        end
        rx_wire = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        enable  = 1'b1;
        rx_wire = 1'b1;
        rx_ack  = 1'b0;
        idle(20);
        assertCount++; if (rx_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
        assertCount++; if (rx_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        assertCount++; if (framing_error !== 1'b0) begin failCount++; $display("[TB] FAIL reset_fe: got %b expected 0", framing_error); end
        assertCount++; if (overrun !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ov: got %b expected 0", overrun); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_single_frame();
        int feBase, ovBase, riseClk, busyMid;
        logic found, busyAtRise;
        do_reset();
        feBase = feSeen; ovBase = ovSeen;
        found = 1'b0; riseClk = 0; busyMid = 0; busyAtRise = 1'b1;
        fork
            drive_line(8'hA5, 1'b1, 160);
            begin
                for (int c = 1; c <= 200 && !found; c++) begin
                    @(negedge clk);
                    if (c == 80) busyMid = busy;
                    if (rx_valid === 1'b1) begin
                        found = 1'b1;
                        riseClk = c;
                        busyAtRise = busy;
                    end
                end
            end
        join
        assertCount++; if (found !== 1'b1) begin failCount++; $display("[TB] FAIL a5_timeout: got valid=%b expected 1 within 200 clk", found); end
        assertCount++; if (riseClk < 145 || riseClk > 165) begin failCount++; $display("[TB] FAIL a5_latency: got %0d clk expected 145..165", riseClk); end
        assertCount++; if (busyMid !== 1) begin failCount++; $display("[TB] FAIL a5_busy_mid: got %0d expected 1", busyMid); end
        assertCount++; if (busyAtRise !== 1'b0) begin failCount++; $display("[TB] FAIL a5_busy_drop: got %b expected 0", busyAtRise); end
        idle(20);
        assertCount++; if (rx_data !== 8'hA5) begin failCount++; $display("[TB] FAIL a5_data: got %h expected a5", rx_data); end
        assertCount++; if (rx_valid !== 1'b1) begin failCount++; $display("[TB] FAIL a5_valid_held: got %b expected 1", rx_valid); end
        assertCount++; if ((feSeen - feBase) !== 0 || (ovSeen - ovBase) !== 0) begin failCount++; $display("[TB] FAIL a5_errors: got fe=%0d ov=%0d expected 0 0", feSeen - feBase, ovSeen - ovBase); end
    endtask

    task automatic test_glitch();
        int feBase;
        do_reset();
        feBase = feSeen;
        rx_wire = 1'b0;
        idle(4);
        rx_wire = 1'b1;
        idle(200);
        assertCount++; if (rx_valid !== 1'b0) begin failCount++; $display("[TB] FAIL glitch_valid: got %b expected 0", rx_valid); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
        assertCount++; if ((feSeen - feBase) !== 0) begin failCount++; $display("[TB] FAIL glitch_fe: got %0d expected 0", feSeen - feBase); end
    endtask

    task automatic test_framing_error();
        int feBase, ovBase;
        do_reset();
        feBase = feSeen; ovBase = ovSeen;
        drive_line(8'h3C, 1'b0, 160);
        idle(40);
        assertCount++; if ((feSeen - feBase) !== 1) begin failCount++; $display("[TB] FAIL fe_pulse: got %0d clk expected 1", feSeen - feBase); end
        assertCount++; if (rx_valid !== 1'b0) begin failCount++; $display("[TB] FAIL fe_valid: got %b expected 0", rx_valid); end
        assertCount++; if ((ovSeen - ovBase) !== 0) begin failCount++; $display("[TB] FAIL fe_ov: got %0d expected 0", ovSeen - ovBase); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL fe_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overrun();
        int feBase, ovBase;
        do_reset();
        feBase = feSeen; ovBase = ovSeen;
        drive_line(8'h11, 1'b1, 160);
        drive_line(8'h22, 1'b1, 160);
        idle(20);
        assertCount++; if (rx_data !== 8'h11) begin failCount++; $display("[TB] FAIL ov_data: got %h expected 11", rx_data); end
        assertCount++; if (rx_valid !== 1'b1) begin failCount++; $display("[TB] FAIL ov_valid: got %b expected 1", rx_valid); end
        assertCount++; if ((ovSeen - ovBase) !== 1) begin failCount++; $display("[TB] FAIL ov_pulse: got %0d clk expected 1", ovSeen - ovBase); end
        assertCount++; if ((feSeen - feBase) !== 0) begin failCount++; $display("[TB] FAIL ov_fe: got %0d expected 0", feSeen - feBase); end
    endtask

    task automatic test_back_to_back();
        int ovBase;
        do_reset();
        ovBase = ovSeen;
        drive_line(8'h11, 1'b1, 160);
        fork
            drive_line(8'h22, 1'b1, 160);
            begin
                idle(154);
                rx_ack = 1'b1;
                idle(1);
                rx_ack = 1'b0;
            end
        join
        idle(20);
        assertCount++; if (rx_data !== 8'h22) begin failCount++; $display("[TB] FAIL b2b_data: got %h expected 22", rx_data); end
        assertCount++; if (rx_valid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid: got %b expected 1", rx_valid); end
        assertCount++; if ((ovSeen - ovBase) !== 0) begin failCount++; $display("[TB] FAIL b2b_ov: got %0d expected 0", ovSeen - ovBase); end
    endtask

    task automatic test_reset_mid_frame();
        int feBase, ovBase;
        do_reset();
        drive_line(8'hC3, 1'b1, 160);
        idle(10);
        assertCount++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin failCount++; $display("[TB] FAIL rmf_pre: got %h/%b expected c3/1", rx_data, rx_valid); end
        drive_line(8'hFF, 1'b1, 60);
        assertCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL rmf_busy_pre: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        assertCount++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rmf_clear: got %h/%b expected 00/0", rx_data, rx_valid); end
        assertCount++; if (busy !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin failCount++; $display("[TB] FAIL rmf_flags: got busy=%b fe=%b ov=%b expected 0 0 0", busy, framing_error, overrun); end
        idle(5);
        rst = 1'b0;
        idle(20);
        feBase = feSeen; ovBase = ovSeen;
        drive_line(8'h5A, 1'b1, 160);
        idle(20);
        assertCount++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin failCount++; $display("[TB] FAIL rmf_next: got %h/%b expected 5a/1", rx_data, rx_valid); end
        assertCount++; if ((feSeen - feBase) !== 0 || (ovSeen - ovBase) !== 0) begin failCount++; $display("[TB] FAIL rmf_errors: got fe=%0d ov=%0d expected 0 0", feSeen - feBase, ovSeen - ovBase); end
    endtask

    task automatic test_enable_toggle();
        int feBase, ovBase;
        do_reset();
        drive_line(8'h66, 1'b1, 160);
        idle(10);
        feBase = feSeen; ovBase = ovSeen;
        drive_line(8'hA5, 1'b1, 50);
        enable = 1'b0;
        idle(10);
        enable = 1'b1;
        idle(200);
        assertCount++; if ((feSeen - feBase) !== 0 || (ovSeen - ovBase) !== 0) begin failCount++; $display("[TB] FAIL en_errors: got fe=%0d ov=%0d expected 0 0", feSeen - feBase, ovSeen - ovBase); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL en_busy: got %b expected 0", busy); end
        assertCount++; if (rx_valid !== 1'b1 || rx_data !== 8'h66) begin failCount++; $display("[TB] FAIL en_retained: got %h/%b expected 66/1", rx_data, rx_valid); end
        enable = 1'b0;
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
        idle(2);
        assertCount++; if (rx_valid !== 1'b0) begin failCount++; $display("[TB] FAIL en_ack_disabled: got %b expected 0", rx_valid); end
        enable = 1'b1;
        idle(5);
        drive_line(8'h81, 1'b1, 160);
        idle(20);
        assertCount++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin failCount++; $display("[TB] FAIL en_next: got %h/%b expected 81/1", rx_data, rx_valid); end
    endtask

    // Random frames against a word-level model of delivery, ack and errors
    task automatic test_random();
        logic       mValid;
        logic [7:0] mData;
        logic [7:0] b;
        logic       stopGood;
        int         expFe, expOv, feBase, ovBase;
        do_reset();
        mValid = 1'b0; mData = 8'h00; expFe = 0; expOv = 0;
        feBase = feSeen; ovBase = ovSeen;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            stopGood = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) begin
                rx_ack = 1'b1;
                idle(1);
                rx_ack = 1'b0;
                mValid = 1'b0;
            end
            idle($urandom_range(0, 20));
            drive_line(b, stopGood, 160);
            idle(20);
            if (!stopGood) expFe++;
            else if (!mValid) begin mData = b; mValid = 1'b1; end
            else expOv++;
            assertCount++; if (rx_valid !== mValid) begin failCount++; $display("[TB] FAIL rnd%0d_valid: got %b expected %b", n, rx_valid, mValid); end
            assertCount++; if (rx_data !== mData) begin failCount++; $display("[TB] FAIL rnd%0d_data: got %h expected %h", n, rx_data, mData); end
            assertCount++; if ((feSeen - feBase) !== expFe) begin failCount++; $display("[TB] FAIL rnd%0d_fe: got %0d expected %0d", n, feSeen - feBase, expFe); end
            assertCount++; if ((ovSeen - ovBase) !== expOv) begin failCount++; $display("[TB] FAIL rnd%0d_ov: got %0d expected %0d", n, ovSeen - ovBase, expOv); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        rx_wire = 1'b1;
        rx_ack  = 1'b0;
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
